// File: rtl/jace_pkg.sv
// rtl/jace_pkg.sv - shared tape player state encoding and default tape timing constants
package jace_pkg;

  typedef logic [23:0] half_t;

  localparam int unsigned TAPE_LEADER_HALF   = 15578;
  localparam int unsigned TAPE_LEADER_CYCLES = 4096;
  localparam int unsigned TAPE_SYNC_HALF     = 4000;
  localparam int unsigned TAPE_ZERO_HALF     = 6000;
  localparam int unsigned TAPE_ONE_HALF      = 12000;
  localparam int unsigned TAPE_GAP_CYCLES    = 2500000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEADER,
    ST_SYNC_HI,
    ST_SYNC_LO,
    ST_FETCH,
    ST_BIT_HI,
    ST_BIT_LO,
    ST_END_HI,
    ST_GAP
  } tape_state_t;

  // Counters run from N-1 down to 0 so a level lasts exactly N cycles.
  function automatic half_t tape_half_m1(input int unsigned n);
    return half_t'(n - 1);
  endfunction

endpackage

// File: rtl/jace_tape_halfcnt.sv
// rtl/jace_tape_halfcnt.sv - loadable half-period down-counter with zero flag
module jace_tape_halfcnt
  import jace_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  half_t load_val,
  output logic  zero
);

  half_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - half_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/jace_tape_player.sv
// rtl/jace_tape_player.sv - Jupiter Ace cassette waveform generator fed by a byte stream
// Optional JACE_TAPE_CHECKSUM_EN appends the XOR of the block's bytes as a trailing byte.
module jace_tape_player
  import jace_pkg::*;
#(
  parameter int unsigned LEADER_HALF   = TAPE_LEADER_HALF,
  parameter int unsigned LEADER_CYCLES = TAPE_LEADER_CYCLES,
  parameter int unsigned SYNC_HALF     = TAPE_SYNC_HALF,
  parameter int unsigned ZERO_HALF     = TAPE_ZERO_HALF,
  parameter int unsigned ONE_HALF      = TAPE_ONE_HALF,
  parameter int unsigned GAP_CYCLES    = TAPE_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_last,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       ear,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam half_t LEAD_M1 = tape_half_m1(LEADER_HALF);
  localparam half_t SYNC_M1 = tape_half_m1(SYNC_HALF);
  localparam half_t ZERO_M1 = tape_half_m1(ZERO_HALF);
  localparam half_t ONE_M1  = tape_half_m1(ONE_HALF);
  localparam half_t GAP_M1  = tape_half_m1(GAP_CYCLES);

  tape_state_t state_q, state_d;
  logic        lead_hi_q, lead_hi_d;
  logic [15:0] cyc_q, cyc_d;
  logic [7:0]  shift_q, shift_d;
  logic        last_q, last_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        first_q, first_d;
  logic        underrun_q, underrun_d;
`ifdef JACE_TAPE_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
  logic        cks_q, cks_d;
`endif

  logic  cnt_load;
  half_t cnt_val;
  logic  cnt_zero;

  jace_tape_halfcnt u_halfcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lead_hi_q  <= 1'b0;
      cyc_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      bit_idx_q  <= '0;
      first_q    <= 1'b0;
      underrun_q <= 1'b0;
`ifdef JACE_TAPE_CHECKSUM_EN
      xor_q      <= '0;
      cks_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lead_hi_q  <= lead_hi_d;
      cyc_q      <= cyc_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      bit_idx_q  <= bit_idx_d;
      first_q    <= first_d;
      underrun_q <= underrun_d;
`ifdef JACE_TAPE_CHECKSUM_EN
      xor_q      <= xor_d;
      cks_q      <= cks_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    lead_hi_d  = lead_hi_q;
    cyc_d      = cyc_q;
    shift_d    = shift_q;
    last_d     = last_q;
    bit_idx_d  = bit_idx_q;
    first_d    = 1'b0;
    underrun_d = underrun_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
`ifdef JACE_TAPE_CHECKSUM_EN
    xor_d      = xor_q;
    cks_d      = cks_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LEADER;
          lead_hi_d  = 1'b1;
          cyc_d      = 16'(LEADER_CYCLES);
          underrun_d = 1'b0;
          cnt_load   = 1'b1;
          cnt_val    = LEAD_M1;
`ifdef JACE_TAPE_CHECKSUM_EN
          xor_d      = '0;
          cks_d      = 1'b0;
`endif
        end
      end

      // One leader cycle is counted off on each high-to-low transition.
      ST_LEADER: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = LEAD_M1;
          if (lead_hi_q) begin
            lead_hi_d = 1'b0;
            cyc_d     = cyc_q - 16'd1;
          end else if (cyc_q == '0) begin
            state_d = ST_SYNC_HI;
            cnt_val = SYNC_M1;
          end else begin
            lead_hi_d = 1'b1;
          end
        end
      end

      ST_SYNC_HI: begin
        if (cnt_zero) begin
          state_d  = ST_SYNC_LO;
          cnt_load = 1'b1;
          cnt_val  = SYNC_M1;
        end
      end

      ST_SYNC_LO: begin
        if (cnt_zero) begin
          state_d = ST_FETCH;
          first_d = 1'b1;
        end
      end

      ST_FETCH: begin
        if (byte_valid) begin
          state_d   = ST_BIT_HI;
          shift_d   = byte_data;
          last_d    = byte_last;
          bit_idx_d = 3'd7;
          cnt_load  = 1'b1;
          cnt_val   = byte_data[7] ? ONE_M1 : ZERO_M1;
`ifdef JACE_TAPE_CHECKSUM_EN
          xor_d     = xor_q ^ byte_data;
`endif
        end else if (first_q) begin
          underrun_d = 1'b1;
        end
      end

      ST_BIT_HI: begin
        if (cnt_zero) begin
          state_d  = ST_BIT_LO;
          cnt_load = 1'b1;
          cnt_val  = shift_q[bit_idx_q] ? ONE_M1 : ZERO_M1;
        end
      end

      ST_BIT_LO: begin
        if (cnt_zero) begin
          if (bit_idx_q != 3'd0) begin
            state_d   = ST_BIT_HI;
            bit_idx_d = bit_idx_q - 3'd1;
            cnt_load  = 1'b1;
            cnt_val   = shift_q[bit_idx_q - 3'd1] ? ONE_M1 : ZERO_M1;
          end else if (!last_q) begin
            state_d = ST_FETCH;
            first_d = 1'b1;
`ifdef JACE_TAPE_CHECKSUM_EN
          end else if (!cks_q) begin
            state_d   = ST_BIT_HI;
            shift_d   = xor_q;
            cks_d     = 1'b1;
            bit_idx_d = 3'd7;
            cnt_load  = 1'b1;
            cnt_val   = xor_q[7] ? ONE_M1 : ZERO_M1;
`endif
          end else begin
            state_d  = ST_END_HI;
            cnt_load = 1'b1;
            cnt_val  = ZERO_M1;
          end
        end
      end

      ST_END_HI: begin
        if (cnt_zero) begin
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = GAP_M1;
        end
      end

      ST_GAP: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ear        = 1'b0;
    byte_ready = 1'b0;
    busy       = (state_q != ST_IDLE);
    done       = 1'b0;
    unique case (state_q)
      ST_LEADER:                       ear = lead_hi_q;
      ST_SYNC_HI, ST_BIT_HI, ST_END_HI: ear = 1'b1;
      ST_FETCH:                        byte_ready = 1'b1;
      ST_GAP:                          done = cnt_zero;
      default:                         ;
    endcase
  end

  assign underrun = underrun_q;

endmodule

// File: tb/tb_jace_tape_player.sv
// tb/tb_jace_tape_player.sv - directed bench for jace_tape_player with small timing parameters
module tb_jace_tape_player;

  localparam int unsigned L_HALF = 3;
  localparam int unsigned L_CYC  = 4;
  localparam int unsigned S_HALF = 2;
  localparam int unsigned Z_HALF = 3;
  localparam int unsigned O_HALF = 6;
  localparam int unsigned G_CYC  = 5;
  localparam int LEADER_TRACE = 24'hE38E38;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_last = 1'b0;
  logic       byte_valid = 1'b0;
  logic       byte_ready, ear, busy, done, underrun;

  int total = 0;
  int bad = 0;
  int ready_cnt = 0;
  int done_cnt = 0;
  logic [8:0] src_q[$];

  jace_tape_player #(
    .LEADER_HALF   (L_HALF),
    .LEADER_CYCLES (L_CYC),
    .SYNC_HALF     (S_HALF),
    .ZERO_HALF     (Z_HALF),
    .ONE_HALF      (O_HALF),
    .GAP_CYCLES    (G_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ear        (ear),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic src_load();
    if (src_q.size() > 0) begin
      {byte_last, byte_data} = src_q.pop_front();
      byte_valid = 1'b1;
    end else begin
      byte_valid = 1'b0;
    end
  endtask

  task automatic step();
    logic fire;
    fire = byte_valid && byte_ready;
    @(posedge clk);
    #1;
    if (fire) src_load();
    if (byte_ready) ready_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic leader_trace(output logic [23:0] tr, input int restart_at);
    for (int i = 0; i < 24; i++) begin
      tr[23-i] = ear;
      if (i == restart_at) start = 1'b1;
      step();
      start = 1'b0;
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!byte_ready && n < 500) begin
      step();
      n++;
    end
    chk(tag, byte_ready, 1);
  endtask

  task automatic measure_high(output int w);
    int g;
    g = 0;
    w = 0;
    while (ear == 1'b0 && g < 200) begin
      step();
      g++;
    end
    while (ear == 1'b1 && w < 200) begin
      step();
      w++;
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b);
    int w;
    for (int i = 7; i >= 0; i--) begin
      measure_high(w);
      chk($sformatf("%s_bit%0d", tag, i), w, b[i] ? O_HALF : Z_HALF);
    end
  endtask

  task automatic finish_block(input string tag, input bit start_at_done);
    int w;
    int n;
    measure_high(w);
    chk({tag, "_end"}, w, Z_HALF);
    n = 0;
    while (n < 100) begin
      n++;
      if (done) break;
      step();
    end
    chk({tag, "_gap"}, n, G_CYC);
    if (start_at_done) start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [23:0] tr;
    logic [3:0]  sy;
    logic        hold_bad;

    #1;
    chk("rst_ear", ear, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // Block A: leader shape, sync, 0xA5 pulse widths
    src_q.push_back({1'b1, 8'hA5});
    src_load();
    do_start();
    chk("a_busy", busy, 1);
    leader_trace(tr, -1);
    chk("a_leader", tr, LEADER_TRACE);
    for (int i = 0; i < 4; i++) begin
      sy[3-i] = ear;
      step();
    end
    chk("a_sync", sy, 4'b1100);
    chk("a_fetch_ready", byte_ready, 1);
    expect_byte("a", 8'hA5);
`ifdef JACE_TAPE_CHECKSUM_EN
    expect_byte("a_cks", 8'hA5);
`endif
    finish_block("a", 1'b0);
    chk("a_underrun", underrun, 0);

    // Block B: starved fetch
    do_start();
    wait_ready("b_ready");
    hold_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ear || !byte_ready) hold_bad = 1'b1;
    end
    chk("b_underrun", underrun, 1);
    chk("b_hold", hold_bad, 0);
    src_q.push_back({1'b1, 8'h3C});
    src_load();
    expect_byte("b", 8'h3C);
`ifdef JACE_TAPE_CHECKSUM_EN
    expect_byte("b_cks", 8'h3C);
`endif
    finish_block("b", 1'b0);
    chk("b_sticky", underrun, 1);

    // Block C: start pulses during leader and on the done cycle are ignored
    src_q.push_back({1'b1, 8'h81});
    src_load();
    do_start();
    chk("c_underrun_clr", underrun, 0);
    done_cnt = 0;
    leader_trace(tr, 5);
    chk("c_leader", tr, LEADER_TRACE);
    wait_ready("c_ready");
    expect_byte("c", 8'h81);
`ifdef JACE_TAPE_CHECKSUM_EN
    expect_byte("c_cks", 8'h81);
`endif
    finish_block("c", 1'b1);
    for (int i = 0; i < 20; i++) step();
    chk("c_done_cnt", done_cnt, 1);
    chk("c_still_idle", busy, 0);

    // Block D: asynchronous reset in the middle of a bit
    src_q.push_back({1'b1, 8'hFF});
    src_load();
    do_start();
    wait_ready("d_ready");
    step();
    chk("d_bit_hi", ear, 1);
    step();
    reset = 1'b1;
    #1;
    chk("d_rst_ear", ear, 0);
    chk("d_rst_busy", busy, 0);
    chk("d_rst_ready", byte_ready, 0);
    #1;
    reset = 1'b0;
    step();

    // Block E: full block after reset
    src_q.push_back({1'b1, 8'h00});
    src_load();
    do_start();
    leader_trace(tr, -1);
    chk("e_leader", tr, LEADER_TRACE);
    wait_ready("e_ready");
    expect_byte("e", 8'h00);
`ifdef JACE_TAPE_CHECKSUM_EN
    expect_byte("e_cks", 8'h00);
`endif
    finish_block("e", 1'b0);

    // Block F: two-byte block, trailing checksum needs no handshake
    src_q.push_back({1'b0, 8'h12});
    src_q.push_back({1'b1, 8'h34});
    src_load();
    do_start();
    wait_ready("f_ready");
    expect_byte("f0", 8'h12);
    expect_byte("f1", 8'h34);
    ready_cnt = 0;
`ifdef JACE_TAPE_CHECKSUM_EN
    expect_byte("f_cks", 8'h26);
`endif
    finish_block("f", 1'b0);
    chk("f_no_ready", ready_cnt, 0);
    chk("f_underrun", underrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
